// File: rtl/mem_access_sequencer_if.sv
// ---------------------------------------------------------------------------
// mem_access_sequencer_if
// Byte-wide data-memory port with a req/ack handshake.
//   mem_req   : access request (sequencer -> memory)
//   mem_we    : write strobe, qualified by mem_req
//   mem_addr  : 16-bit byte address
//   mem_wdata : write data byte
//   mem_ack   : memory completes the access in this cycle (memory -> sequencer)
//   mem_rdata : read data byte, valid when mem_ack=1
// Modports: master = sequencer side, slave = memory side.
// ---------------------------------------------------------------------------
interface mem_access_sequencer_if;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack;
  logic [7:0]  mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_access_sequencer.sv
// ---------------------------------------------------------------------------
// mem_access_sequencer
// MEM-stage controller: runs one load/store as up to two byte accesses
// (top byte at op_addr, then bottom byte at op_addr+1) over a single 8-bit
// req/ack memory port, stalling the pipeline while the op is in flight.
//
// Ports:
//   clock, reset_n       : clock (rising edge), synchronous active-low reset
//   op_valid/op_is_store : operation present / store(1) or load(0)
//   op_byte_en[1:0]      : [0] top byte, [1] bottom byte
//   op_addr, st_data_*   : top-byte address, store data bytes
//   mem                  : memory port (mem_access_sequencer_if.master)
//   ld_res_top/bot       : captured load bytes (held until overwritten)
//   sel_signals[1:0]     : MEM/WB lane select, 1 = take load result (DONE only)
//   stall                : freeze IF..EX/MEM (combinational)
//   op_done              : one-cycle completion pulse
//   timeout_err          : sticky access-timeout flag
//
// Build option: define MEM_SEQ_TIMEOUT_EN to abort an access after
// TIMEOUT_CYCLES request cycles without an ack; otherwise the sequencer
// waits indefinitely and timeout_err is tied low.
// ---------------------------------------------------------------------------
module mem_access_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          op_valid,
  input  logic                          op_is_store,
  input  logic [1:0]                    op_byte_en,
  input  logic [15:0]                   op_addr,
  input  logic [7:0]                    st_data_top,
  input  logic [7:0]                    st_data_bot,
  mem_access_sequencer_if.master        mem,
  output logic [7:0]                    ld_res_top,
  output logic [7:0]                    ld_res_bot,
  output logic [1:0]                    sel_signals,
  output logic                          stall,
  output logic                          op_done,
  output logic                          timeout_err
);

  typedef enum logic [1:0] {IDLE, ACC_TOP, ACC_BOT, DONE} state_t;

  state_t      state_reg;
  logic        store_reg;
  logic [1:0]  en_reg;
  logic [15:0] addr_reg;
  logic [7:0]  data_bot_reg;

  // Lane selects presented in DONE for a completed (non-aborted) op.
  logic [1:0]  done_sel;
  assign done_sel = {en_reg[1] & ~store_reg, en_reg[0] & ~store_reg};

  // Stall covers the accept cycle too, so EX/MEM holds the op until DONE.
  assign stall = ((state_reg == IDLE) && op_valid && (op_byte_en != 2'b00)) ||
                 (state_reg == ACC_TOP) || (state_reg == ACC_BOT);

`ifdef MEM_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt_reg;
  logic             timeout_hit;
  // Abort on the edge that would bring the count to TIMEOUT_CYCLES, so req
  // stays high for exactly TIMEOUT_CYCLES cycles.
  assign timeout_hit = !mem.mem_ack && (wait_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_err        = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      store_reg     <= 1'b0;
      en_reg        <= 2'b00;
      addr_reg      <= 16'h0000;
      data_bot_reg  <= 8'h00;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= 16'h0000;
      mem.mem_wdata <= 8'h00;
      ld_res_top    <= 8'h00;
      ld_res_bot    <= 8'h00;
      sel_signals   <= 2'b00;
      op_done       <= 1'b0;
`ifdef MEM_SEQ_TIMEOUT_EN
      wait_cnt_reg  <= '0;
      timeout_err   <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          op_done     <= 1'b0;
          sel_signals <= 2'b00;
          if (op_valid && (op_byte_en != 2'b00)) begin
            store_reg    <= op_is_store;
            en_reg       <= op_byte_en;
            addr_reg     <= op_addr;
            data_bot_reg <= st_data_bot;
            mem.mem_req  <= 1'b1;
            mem.mem_we   <= op_is_store;
`ifdef MEM_SEQ_TIMEOUT_EN
            wait_cnt_reg <= '0;
`endif
            if (op_byte_en[0]) begin
              state_reg     <= ACC_TOP;
              mem.mem_addr  <= op_addr;
              mem.mem_wdata <= st_data_top;
            end else begin
              state_reg     <= ACC_BOT;
              mem.mem_addr  <= op_addr + 16'd1;
              mem.mem_wdata <= st_data_bot;
            end
          end
        end

        ACC_TOP: begin
          if (mem.mem_ack) begin
            if (!store_reg) ld_res_top <= mem.mem_rdata;
            if (en_reg[1]) begin
              // Back-to-back: req stays high, address/data switch on this edge.
              state_reg     <= ACC_BOT;
              mem.mem_addr  <= addr_reg + 16'd1;
              mem.mem_wdata <= data_bot_reg;
`ifdef MEM_SEQ_TIMEOUT_EN
              wait_cnt_reg  <= '0;
`endif
            end else begin
              state_reg   <= DONE;
              mem.mem_req <= 1'b0;
              mem.mem_we  <= 1'b0;
              op_done     <= 1'b1;
              sel_signals <= done_sel;
            end
          end
`ifdef MEM_SEQ_TIMEOUT_EN
          else if (timeout_hit) begin
            state_reg   <= DONE;
            mem.mem_req <= 1'b0;
            mem.mem_we  <= 1'b0;
            op_done     <= 1'b1;
            sel_signals <= 2'b00;
            timeout_err <= 1'b1;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end
`endif
        end

        ACC_BOT: begin
          if (mem.mem_ack) begin
            if (!store_reg) ld_res_bot <= mem.mem_rdata;
            state_reg   <= DONE;
            mem.mem_req <= 1'b0;
            mem.mem_we  <= 1'b0;
            op_done     <= 1'b1;
            sel_signals <= done_sel;
          end
`ifdef MEM_SEQ_TIMEOUT_EN
          else if (timeout_hit) begin
            state_reg   <= DONE;
            mem.mem_req <= 1'b0;
            mem.mem_we  <= 1'b0;
            op_done     <= 1'b1;
            sel_signals <= 2'b00;
            timeout_err <= 1'b1;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end
`endif
        end

        default: begin // DONE
          state_reg   <= IDLE;
          op_done     <= 1'b0;
          sel_signals <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_sequencer.sv
module tb_mem_access_sequencer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        op_valid;
  logic        op_is_store;
  logic [1:0]  op_byte_en;
  logic [15:0] op_addr;
  logic [7:0]  st_data_top;
  logic [7:0]  st_data_bot;
  logic [7:0]  ld_res_top;
  logic [7:0]  ld_res_bot;
  logic [1:0]  sel_signals;
  logic        stall;
  logic        op_done;
  logic        timeout_err;

  mem_access_sequencer_if mif ();

  mem_access_sequencer #(.TIMEOUT_CYCLES(4)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .op_valid    (op_valid),
    .op_is_store (op_is_store),
    .op_byte_en  (op_byte_en),
    .op_addr     (op_addr),
    .st_data_top (st_data_top),
    .st_data_bot (st_data_bot),
    .mem         (mif.master),
    .ld_res_top  (ld_res_top),
    .ld_res_bot  (ld_res_bot),
    .sel_signals (sel_signals),
    .stall       (stall),
    .op_done     (op_done),
    .timeout_err (timeout_err)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard of expected memory accesses, pushed by the op driver.
  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    int          waits;
  } acc_t;

  acc_t exp_q[$];
  acc_t cur;
  logic active = 1'b0;
  int   wait_left = 0;
  int   req_cycles = 0;
  logic idle_noise = 1'b0;

  // Memory responder: evaluates on the falling edge, drives ack/rdata for
  // the next rising edge. Toggles ack while req is low (must be ignored).
  always @(negedge clock) begin
    if (!reset_n || !mif.mem_req) begin
      active      = 1'b0;
      idle_noise  = ~idle_noise;
      mif.mem_ack = reset_n ? idle_noise : 1'b0;
      mif.mem_rdata = 8'hEE;
    end else begin
      req_cycles++;
      if (!active) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_req: got req at addr %0h, expected no access", mif.mem_addr);
          mif.mem_ack = 1'b1;
        end else begin
          cur       = exp_q.pop_front();
          active    = 1'b1;
          wait_left = cur.waits;
          check("acc_we",   {31'd0, mif.mem_we}, {31'd0, cur.we});
          check("acc_addr", {16'd0, mif.mem_addr}, {16'd0, cur.addr});
          if (cur.we) check("acc_wdata", {24'd0, mif.mem_wdata}, {24'd0, cur.wdata});
        end
      end else begin
        check("hold_we",   {31'd0, mif.mem_we}, {31'd0, cur.we});
        check("hold_addr", {16'd0, mif.mem_addr}, {16'd0, cur.addr});
        if (cur.we) check("hold_wdata", {24'd0, mif.mem_wdata}, {24'd0, cur.wdata});
      end
      if (active) begin
        if (wait_left == 0) begin
          mif.mem_ack   = 1'b1;
          mif.mem_rdata = cur.rdata;
          active        = 1'b0;
        end else begin
          mif.mem_ack   = 1'b0;
          mif.mem_rdata = 8'hEE;
          wait_left--;
        end
      end
    end
  end

  task automatic push_acc(input logic we, input logic [15:0] addr, input logic [7:0] wd,
                          input logic [7:0] rd, input int waits);
    acc_t a;
    a.we = we; a.addr = addr; a.wdata = wd; a.rdata = rd; a.waits = waits;
    exp_q.push_back(a);
  endtask

  // Drive one op, wait for op_done, check lane selects, load bytes,
  // latency (cycles from accept edge to DONE) and request-cycle count.
  task automatic run_op(input logic st, input logic [1:0] en, input logic [15:0] addr,
                        input logic [7:0] dt, input logic [7:0] db,
                        input logic [7:0] rt, input logic [7:0] rb, input int waits,
                        input logic [1:0] e_sel, input logic [7:0] e_top, input logic [7:0] e_bot,
                        input int e_lat, input int e_reqc);
    int   cyc;
    int   req_base;
    logic stall_ok;
    logic [15:0] addr_bot;
    addr_bot = addr + 16'd1;
    if (en[0]) push_acc(st, addr, dt, rt, waits);
    if (en[1]) push_acc(st, addr_bot, db, rb, waits);
    @(negedge clock);
    req_base    = req_cycles;
    op_valid    = 1'b1;
    op_is_store = st;
    op_byte_en  = en;
    op_addr     = addr;
    st_data_top = dt;
    st_data_bot = db;
    #1 check("stall_accept", {31'd0, stall}, 32'd1);
    @(negedge clock);
    op_valid = 1'b0;
    cyc      = 1;
    stall_ok = 1'b1;
    while (!op_done && cyc < 40) begin
      if (!stall) stall_ok = 1'b0;
      @(negedge clock);
      cyc++;
    end
    #1;
    check("done_seen",  {31'd0, op_done}, 32'd1);
    check("latency",    cyc, e_lat);
    check("stall_busy", {31'd0, stall_ok}, 32'd1);
    check("stall_done", {31'd0, stall}, 32'd0);
    check("req_done",   {31'd0, mif.mem_req}, 32'd0);
    check("sel",        {30'd0, sel_signals}, {30'd0, e_sel});
    check("ld_top",     {24'd0, ld_res_top}, {24'd0, e_top});
    check("ld_bot",     {24'd0, ld_res_bot}, {24'd0, e_bot});
    check("req_cycles", req_cycles - req_base, e_reqc);
    check("sb_empty",   exp_q.size(), 32'd0);
    @(negedge clock);
    check("done_pulse", {31'd0, op_done}, 32'd0);
    check("sel_idle",   {30'd0, sel_signals}, 32'd0);
    exp_q.delete();
  endtask

  typedef struct {
    logic        st;
    logic [1:0]  en;
    logic [15:0] addr;
    logic [7:0]  dt, db, rt, rb;
    int          waits;
    logic [1:0]  e_sel;
    logic [7:0]  e_top, e_bot;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int nb;
    int cyc;
    vecs[0] = '{1'b0, 2'b11, 16'h1234, 8'h00, 8'h00, 8'hAB, 8'hCD, 0, 2'b11, 8'hAB, 8'hCD};
    vecs[1] = '{1'b1, 2'b01, 16'h2000, 8'h5A, 8'h77, 8'h00, 8'h00, 3, 2'b00, 8'hAB, 8'hCD};
    vecs[2] = '{1'b0, 2'b10, 16'hFFFF, 8'h00, 8'h00, 8'h00, 8'h3C, 0, 2'b10, 8'hAB, 8'h3C};
    vecs[3] = '{1'b0, 2'b01, 16'h0010, 8'h00, 8'h00, 8'h99, 8'h00, 1, 2'b01, 8'h99, 8'h3C};
    vecs[4] = '{1'b1, 2'b11, 16'hFFFF, 8'h11, 8'h22, 8'h00, 8'h00, 2, 2'b00, 8'h99, 8'h3C};
    vecs[5] = '{1'b0, 2'b11, 16'h8000, 8'h00, 8'h00, 8'h01, 8'h02, 1, 2'b11, 8'h01, 8'h02};

    reset_n = 1'b0; op_valid = 1'b0; op_is_store = 1'b0; op_byte_en = 2'b00;
    op_addr = 16'h0; st_data_top = 8'h0; st_data_bot = 8'h0;
    mif.mem_ack = 1'b0; mif.mem_rdata = 8'h00;
    repeat (3) @(negedge clock);
    check("rst_req",   {31'd0, mif.mem_req}, 32'd0);
    check("rst_we",    {31'd0, mif.mem_we}, 32'd0);
    check("rst_addr",  {16'd0, mif.mem_addr}, 32'd0);
    check("rst_wdata", {24'd0, mif.mem_wdata}, 32'd0);
    check("rst_ld",    {16'd0, ld_res_top, ld_res_bot}, 32'd0);
    check("rst_ctl",   {28'd0, sel_signals, op_done, timeout_err}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    reset_n = 1'b1;

    // op_valid with no byte enables: no stall, no access, stays idle.
    @(negedge clock);
    op_valid = 1'b1; op_byte_en = 2'b00; op_addr = 16'h4444;
    #1 check("en0_stall", {31'd0, stall}, 32'd0);
    repeat (2) begin
      @(negedge clock);
      check("en0_req",   {31'd0, mif.mem_req}, 32'd0);
      check("en0_stall", {31'd0, stall}, 32'd0);
      check("en0_done",  {29'd0, op_done, sel_signals}, 32'd0);
    end
    op_valid = 1'b0;

    // Reset during ACC_BOT with req high: access dropped, outputs cleared.
    push_acc(1'b0, 16'h0300, 8'h00, 8'h5F, 0);
    push_acc(1'b0, 16'h0301, 8'h00, 8'h6E, 10);
    @(negedge clock);
    op_valid = 1'b1; op_is_store = 1'b0; op_byte_en = 2'b11; op_addr = 16'h0300;
    @(negedge clock);
    op_valid = 1'b0;
    cyc = 0;
    while (!(mif.mem_req && mif.mem_addr == 16'h0301) && cyc < 10) begin
      @(negedge clock);
      cyc++;
    end
    check("rstmid_in_bot", {31'd0, mif.mem_req}, 32'd1);
    reset_n = 1'b0;
    @(negedge clock);
    #1;
    check("rstmid_req",   {31'd0, mif.mem_req}, 32'd0);
    check("rstmid_bus",   {7'd0, mif.mem_we, mif.mem_addr, mif.mem_wdata}, 32'd0);
    check("rstmid_ld",    {16'd0, ld_res_top, ld_res_bot}, 32'd0);
    check("rstmid_ctl",   {27'd0, sel_signals, op_done, timeout_err, stall}, 32'd0);
    reset_n = 1'b1;
    exp_q.delete();
    repeat (3) begin
      @(negedge clock);
      check("rstmid_quiet", {30'd0, mif.mem_req, op_done}, 32'd0);
    end

    // Table-driven ops.
    for (int i = 0; i < 6; i++) begin
      nb = int'(vecs[i].en[0]) + int'(vecs[i].en[1]);
      run_op(vecs[i].st, vecs[i].en, vecs[i].addr, vecs[i].dt, vecs[i].db,
             vecs[i].rt, vecs[i].rb, vecs[i].waits,
             vecs[i].e_sel, vecs[i].e_top, vecs[i].e_bot,
             nb + 1 + nb * vecs[i].waits, nb * (1 + vecs[i].waits));
      $display("op %0d: st=%0b en=%b addr=%h sel=%b top=%h bot=%h",
               i, vecs[i].st, vecs[i].en, vecs[i].addr, sel_signals, ld_res_top, ld_res_bot);
    end

`ifdef MEM_SEQ_TIMEOUT_EN
    // Never-acked load: req high 4 cycles, DONE with sel 00, sticky error.
    run_op(1'b0, 2'b11, 16'h4000, 8'h00, 8'h00, 8'hF0, 8'hF1, 1000,
           2'b00, 8'h01, 8'h02, 5, 4);
    check("tmo_err_set", {31'd0, timeout_err}, 32'd1);
    run_op(1'b0, 2'b01, 16'h4100, 8'h00, 8'h00, 8'h5E, 8'h00, 0,
           2'b01, 8'h5E, 8'h02, 2, 1);
    check("tmo_err_sticky", {31'd0, timeout_err}, 32'd1);
`else
    check("tmo_err_tied", {31'd0, timeout_err}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
